// File: rtl/mem_access.sv
// Memory stage: runs loads/stores on a req/gnt/rvalid data bus and stalls the pipe until the access retires.
// Handles byte-lane steering, load extension, misalignment drop and bus timeout.
module mem_access #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int BUS_TIMEOUT = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [3:0]            mem_op_i,
  input  logic                  mem_we_i,
  input  logic [ADDR_WIDTH-1:0] mem_addr_i,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  input  logic [4:0]            reg_waddr_i,
  input  logic                  reg_we_i,
  input  logic [DATA_WIDTH-1:0] reg_wdata_i,
  output logic                  dbus_req_o,
  output logic                  dbus_we_o,
  output logic [ADDR_WIDTH-1:0] dbus_addr_o,
  output logic [3:0]            dbus_be_o,
  output logic [DATA_WIDTH-1:0] dbus_wdata_o,
  input  logic                  dbus_gnt_i,
  input  logic                  dbus_rvalid_i,
  input  logic [DATA_WIDTH-1:0] dbus_rdata_i,
  output logic [4:0]            reg_waddr_o,
  output logic                  reg_we_o,
  output logic [DATA_WIDTH-1:0] reg_wdata_o,
  output logic                  stallreq_o,
  output logic                  misalign_o,
  output logic                  bus_err_o
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LW  = 4'd3;
  localparam logic [3:0] OP_LBU = 4'd4;
  localparam logic [3:0] OP_LHU = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;
  localparam logic [8:0] TMO_LIMIT = 9'(BUS_TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic is_load_f(input logic [3:0] op);
    return (op >= OP_LB) && (op <= OP_LHU);
  endfunction

  function automatic logic is_store_f(input logic [3:0] op);
    return (op >= OP_SB) && (op <= OP_SW);
  endfunction

  function automatic logic aligned_f(input logic [3:0] op, input logic [1:0] lane);
    case (op)
      OP_LH, OP_LHU, OP_SH: return !lane[0];
      OP_LW, OP_SW:         return lane == 2'b00;
      default:              return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] be_f(input logic [3:0] op, input logic [1:0] lane);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 4'b0001 << lane;
      OP_LH, OP_LHU, OP_SH: return lane[1] ? 4'b1100 : 4'b0011;
      default:              return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] wdata_f(input logic [3:0] op, input logic [31:0] d);
    case (op)
      OP_SB:   return {4{d[7:0]}};
      OP_SH:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] ext_f(input logic [3:0] op, input logic [1:0] lane,
                                        input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lane, 3'b000} +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    case (op)
      OP_LB:   return {{24{b[7]}}, b};
      OP_LBU:  return {24'd0, b};
      OP_LH:   return {{16{h[15]}}, h};
      OP_LHU:  return {16'd0, h};
      default: return w;
    endcase
  endfunction

  state_t                state_r;
  logic [7:0]            cnt_r;
  logic [DATA_WIDTH-1:0] rdata_r;
  logic [3:0]            op_r;
  logic [1:0]            lane_r;
  logic [4:0]            waddr_r;
  logic                  we_r;
  logic                  err_r;
  logic                  is_mem_s;
  logic                  aligned_s;
  logic                  tmo_s;
  logic                  unused_s;

  // mem_we_i duplicates what mem_op_i already encodes
  assign unused_s  = mem_we_i;
  assign is_mem_s  = is_load_f(mem_op_i) || is_store_f(mem_op_i);
  assign aligned_s = aligned_f(mem_op_i, mem_addr_i[1:0]);

  // Timeout fires on the last permitted REQ/WAIT cycle; a zero limit disables it.
  always_comb begin
    if (TMO_LIMIT != 9'd0) begin
      tmo_s = ({1'b0, cnt_r} + 9'd1) >= TMO_LIMIT;
    end else begin
      tmo_s = 1'b0;
    end
  end

  // Access sequencer with registered bus outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r      <= ST_IDLE;
      cnt_r        <= 8'd0;
      rdata_r      <= '0;
      op_r         <= 4'd0;
      lane_r       <= 2'd0;
      waddr_r      <= 5'd0;
      we_r         <= 1'b0;
      err_r        <= 1'b0;
      dbus_req_o   <= 1'b0;
      dbus_we_o    <= 1'b0;
      dbus_addr_o  <= '0;
      dbus_be_o    <= 4'd0;
      dbus_wdata_o <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (is_mem_s && aligned_s) begin
            op_r         <= mem_op_i;
            lane_r       <= mem_addr_i[1:0];
            waddr_r      <= reg_waddr_i;
            we_r         <= reg_we_i;
            dbus_req_o   <= 1'b1;
            dbus_we_o    <= is_store_f(mem_op_i);
            dbus_addr_o  <= {mem_addr_i[ADDR_WIDTH-1:2], 2'b00};
            dbus_be_o    <= be_f(mem_op_i, mem_addr_i[1:0]);
            dbus_wdata_o <= wdata_f(mem_op_i, mem_data_i);
            state_r      <= ST_REQ;
          end
        end
        ST_REQ: begin
          cnt_r <= cnt_r + 8'd1;
          if (dbus_gnt_i) begin
            dbus_req_o <= 1'b0;
            state_r    <= dbus_we_o ? ST_DONE : ST_WAIT;
          end else if (tmo_s) begin
            dbus_req_o <= 1'b0;
            err_r      <= 1'b1;
            state_r    <= ST_DONE;
          end
        end
        ST_WAIT: begin
          cnt_r <= cnt_r + 8'd1;
          if (dbus_rvalid_i) begin
            rdata_r <= dbus_rdata_i;
            state_r <= ST_DONE;
          end else if (tmo_s) begin
            err_r   <= 1'b1;
            state_r <= ST_DONE;
          end
        end
        ST_DONE: begin
          cnt_r   <= 8'd0;
          err_r   <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Writeback/stall outputs: pass-through in IDLE, retire result in DONE.
  always_comb begin
    reg_waddr_o = 5'd0;
    reg_we_o    = 1'b0;
    reg_wdata_o = '0;
    stallreq_o  = 1'b0;
    misalign_o  = 1'b0;
    bus_err_o   = 1'b0;
    if (rst_i) begin
      stallreq_o = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (!is_mem_s) begin
            reg_waddr_o = reg_waddr_i;
            reg_we_o    = reg_we_i;
            reg_wdata_o = reg_wdata_i;
          end else if (!aligned_s) begin
            reg_waddr_o = reg_waddr_i;
            misalign_o  = 1'b1;
          end else begin
            stallreq_o = 1'b1;
          end
        end
        ST_REQ, ST_WAIT: stallreq_o = 1'b1;
        ST_DONE: begin
          reg_waddr_o = waddr_r;
          if (err_r) begin
            bus_err_o = 1'b1;
          end else if (is_load_f(op_r)) begin
            reg_we_o    = we_r;
            reg_wdata_o = ext_f(op_r, lane_r, rdata_r);
          end else begin
            reg_we_o = 1'b0;
          end
        end
        default: stallreq_o = 1'b0;
      endcase
    end
  end

endmodule
